// File: rtl/poll_pkg.sv
// Shared types and default constants for the sensor poll scheduler.
package poll_pkg;
    localparam int DATA_W      = 16;
    localparam int ACK_TIMEOUT = 1000;
    localparam int MISS_LIMIT  = 6000000;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a history flop for edge detection.
module sync_edge (
    input  logic clk1M,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 resets low, so a level already high at reset release reads as one rising edge
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
endmodule

// File: rtl/sensor_poll_sched.sv
// Polls a sensor reader on each rising edge of the 5 s tick, with ack timeout.
// Define POLL_WATCHDOG_EN to build the tick-stall watchdog driving tick_lost.
module sensor_poll_sched #(
    parameter int DATA_W      = poll_pkg::DATA_W,
    parameter int ACK_TIMEOUT = poll_pkg::ACK_TIMEOUT,
    parameter int MISS_LIMIT  = poll_pkg::MISS_LIMIT
) (
    input  logic              clk1M,
    input  logic              rst_n,
    input  logic              flag_five_sec,
    output logic              sens_req,
    input  logic              sens_ack,
    input  logic [DATA_W-1:0] sens_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_vld,
    output logic              timeout_err,
    output logic              tick_lost
);
    import poll_pkg::*;

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic             rise, fall;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    sync_edge u_sync (
        .clk1M (clk1M),
        .rst_n (rst_n),
        .din   (flag_five_sec),
        .rise  (rise),
        .fall  (fall)
    );

    assign timed_out = (wait_cnt == CNT_LAST);

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Triggers outside IDLE fall through unused, so they are never queued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = REQ;
            REQ:     if (sens_ack || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset drops the request at once
    always_comb begin
        sens_req = (state == REQ);
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n)               wait_cnt <= '0;
        else if (state != REQ)    wait_cnt <= '0;
        else if (!timed_out)      wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            sample      <= '0;
            sample_vld  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sample_vld <= 1'b0;
            // Ack takes priority over a timeout landing in the same cycle
            if (state == REQ && sens_ack) begin
                sample      <= sens_data;
                sample_vld  <= 1'b1;
                timeout_err <= 1'b0;
            end else if (state == REQ && timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef POLL_WATCHDOG_EN
    localparam int                MISS_W   = $clog2(MISS_LIMIT) + 1;
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    logic [MISS_W-1:0] miss_cnt;

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt  <= '0;
            tick_lost <= 1'b0;
        end else begin
            if (rise || fall)              miss_cnt <= '0;
            else if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 1'b1;
            if (miss_cnt == MISS_MAX)      tick_lost <= 1'b1;
        end
    end
`else
    logic wd_unused;
    assign wd_unused = fall ^ (MISS_LIMIT == 0);
    assign tick_lost = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_poll_sched.sv
// Directed bench for sensor_poll_sched: expected samples go through a scoreboard queue.
module tb_sensor_poll_sched;
    localparam int TB_MISS = 400;
`ifdef POLL_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clk1M = 1'b0;
    logic        rst_n;
    logic        flag_five_sec;
    logic        sens_req;
    logic        sens_ack;
    logic [15:0] sens_data;
    logic [15:0] sample;
    logic        sample_vld;
    logic        timeout_err;
    logic        tick_lost;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk1M = ~clk1M;

    sensor_poll_sched #(
        .DATA_W      (16),
        .ACK_TIMEOUT (1000),
        .MISS_LIMIT  (TB_MISS)
    ) dut (
        .clk1M         (clk1M),
        .rst_n         (rst_n),
        .flag_five_sec (flag_five_sec),
        .sens_req      (sens_req),
        .sens_ack      (sens_ack),
        .sens_data     (sens_data),
        .sample        (sample),
        .sample_vld    (sample_vld),
        .timeout_err   (timeout_err),
        .tick_lost     (tick_lost)
    );

    // Scoreboard: every sample_vld must match the oldest expected sample
    always @(negedge clk1M) begin
        if (rst_n && sample_vld) begin
            vld_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_vld: sample=%h with nothing expected", sample);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (sample !== e) begin
                    errors++;
                    $display("FAIL sb_sample: got %h expected %h", sample, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk1M);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Ends at the negedge of the first cycle with sens_req high
    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1M);
            if (sens_req) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_req_start: sens_req=0 expected 1 within 20 cycles", name);
        end
    endtask

    // Drives sens_ack in the n-th cycle of sens_req, counting cycles sens_req stayed high
    task automatic ack_at(input int n, input logic [15:0] d, output int hi);
        hi = 1;
        for (int k = 2; k <= n; k++) begin
            step();
            if (k == n) begin
                sens_ack  = 1'b1;
                sens_data = d;
                exp_q.push_back(d);
            end
            @(negedge clk1M);
            if (sens_req) hi++;
        end
        step();
        sens_ack  = 1'b0;
        sens_data = 16'h0;
        @(negedge clk1M);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flag_five_sec = 1'b0; sens_ack = 1'b0; sens_data = 16'h0;
        idle_cycles(3);
        @(negedge clk1M);
        checks++;
        if ({sens_req, sample, sample_vld, timeout_err, tick_lost} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b sample=%h vld=%b terr=%b lost=%b expected all 0",
                     sens_req, sample, sample_vld, timeout_err, tick_lost);
        end
        step();
        rst_n = 1'b1;
        idle_cycles(5);
        checks++;
        if (sens_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_req: sens_req=%b expected 0", sens_req);
        end
    endtask

    task automatic test_ack();
        int hi, v0;
        v0 = vld_cnt;
        step(); flag_five_sec = 1'b1;
        wait_req("ack");
        ack_at(5, 16'h1234, hi);
        checks++;
        if (hi != 5) begin
            errors++; $display("FAIL ack_req_len: sens_req high %0d cycles expected 5", hi);
        end
        checks++;
        if (sens_req !== 1'b0) begin
            errors++; $display("FAIL ack_req_drop: sens_req=%b expected 0", sens_req);
        end
        checks++;
        if (sample !== 16'h1234 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL ack_sample: sample=%h terr=%b expected 1234/0", sample, timeout_err);
        end
        idle_cycles(10);
        checks++;
        if (vld_cnt - v0 != 1) begin
            errors++; $display("FAIL ack_vld_count: %0d pulses expected 1", vld_cnt - v0);
        end
        flag_five_sec = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_timeout();
        int hi, v0;
        v0 = vld_cnt;
        step(); flag_five_sec = 1'b1;
        wait_req("timeout");
        hi = 1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk1M);
            if (sens_req) hi++;
            else break;
        end
        checks++;
        if (hi != 1000) begin
            errors++; $display("FAIL timeout_req_len: sens_req high %0d cycles expected 1000", hi);
        end
        checks++;
        if (timeout_err !== 1'b1 || sample !== 16'h1234) begin
            errors++; $display("FAIL timeout_flag: terr=%b sample=%h expected 1/1234", timeout_err, sample);
        end
        flag_five_sec = 1'b0;
        idle_cycles(10);
        checks++;
        if (vld_cnt != v0 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: vld=%0d terr=%b expected 0/1", vld_cnt - v0, timeout_err);
        end
    endtask

    task automatic test_ack_at_timeout();
        int hi;
        step(); flag_five_sec = 1'b1;
        wait_req("edge");
        ack_at(1000, 16'hBEEF, hi);
        checks++;
        if (hi != 1000) begin
            errors++; $display("FAIL edge_req_len: sens_req high %0d cycles expected 1000", hi);
        end
        checks++;
        if (sample !== 16'hBEEF || timeout_err !== 1'b0 || sens_req !== 1'b0) begin
            errors++;
            $display("FAIL edge_ack_wins: sample=%h terr=%b req=%b expected beef/0/0",
                     sample, timeout_err, sens_req);
        end
        flag_five_sec = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_back_to_back();
        int v0, extra;
        v0 = vld_cnt;
        step(); flag_five_sec = 1'b1;
        wait_req("b2b");
        idle_cycles(1);
        flag_five_sec = 1'b0;
        idle_cycles(5);
        flag_five_sec = 1'b1;
        idle_cycles(10);
        sens_ack = 1'b1; sens_data = 16'h0A5A; exp_q.push_back(16'h0A5A);
        step();
        sens_ack = 1'b0; sens_data = 16'h0;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk1M);
            if (sens_req) extra++;
        end
        checks++;
        if (extra != 0 || vld_cnt - v0 != 1) begin
            errors++;
            $display("FAIL b2b_dropped: extra req cycles=%0d vld=%0d expected 0/1", extra, vld_cnt - v0);
        end
    endtask

    task automatic test_reset_mid_req();
        int hi, v0;
        flag_five_sec = 1'b0;
        idle_cycles(10);
        flag_five_sec = 1'b1;
        wait_req("rst");
        idle_cycles(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sens_req !== 1'b0) begin
            errors++; $display("FAIL rst_req_async: sens_req=%b expected 0", sens_req);
        end
        idle_cycles(2);
        @(negedge clk1M);
        checks++;
        if ({sens_req, sample, sample_vld, timeout_err, tick_lost} !== 20'h0) begin
            errors++;
            $display("FAIL rst_outputs: req=%b sample=%h vld=%b terr=%b lost=%b expected all 0",
                     sens_req, sample, sample_vld, timeout_err, tick_lost);
        end
        step();
        rst_n = 1'b1;
        v0 = vld_cnt;
        wait_req("rst_release");
        ack_at(2, 16'h5555, hi);
        checks++;
        if (hi != 2 || sample !== 16'h5555) begin
            errors++; $display("FAIL rst_new_req: hi=%0d sample=%h expected 2/5555", hi, sample);
        end
        idle_cycles(40);
        checks++;
        if (vld_cnt - v0 != 1 || sens_req !== 1'b0) begin
            errors++; $display("FAIL rst_single_trigger: vld=%0d req=%b expected 1/0", vld_cnt - v0, sens_req);
        end
    endtask

    task automatic test_watchdog();
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        idle_cycles(TB_MISS - 30);
        checks++;
        if (tick_lost !== 1'b0) begin
            errors++; $display("FAIL wd_early: tick_lost=%b expected 0", tick_lost);
        end
        idle_cycles(40);
        checks++;
        if (tick_lost !== WD_ON) begin
            errors++; $display("FAIL wd_stalled: tick_lost=%b expected %b", tick_lost, WD_ON);
        end
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            flag_five_sec = ~flag_five_sec;
            idle_cycles(150);
            checks++;
            if (tick_lost !== 1'b0) begin
                errors++; $display("FAIL wd_toggling: tick_lost=%b expected 0 at toggle %0d", tick_lost, t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_watchdog();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d expected samples never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
